alu_op_sequencer: RTL

//  Multi-cycle controller that sequences the register-file + ALU datapath for one RV32I ALU instruction at a time.

---
 rtl/alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller that drives the register-file + ALU
// datapath for one RV32I R-type / OP-IMM instruction at a time. An instruction
// is taken over a valid/ready handshake. The result comes back over a second
// valid/ready handshake.
// State sequence: IDLE -> DECODE -> EXEC -> WB -> DONE -> IDLE, with an
// illegal instruction taking DECODE -> ERR -> IDLE instead.
// Every output is a register that is loaded on the edge that enters the state
// where the output applies. With res_ready held high, one instruction
// completes every five cycles.
module alu_op_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [31:0]      i_instr,
    output logic [4:0]       o_dp_rs1,
    output logic [4:0]       o_dp_rs2,
    output logic [4:0]       o_dp_rd,
    output logic [6:0]       o_dp_opcode,
    output logic [3:0]       o_dp_opsel,
    output logic [11:0]      o_dp_imm,
    output logic             o_dp_reg_write,
    input  logic [XLEN-1:0]  i_dp_alu_out,
    input  logic             i_dp_zero,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [XLEN-1:0]  o_res_data,
    output logic             o_res_zero,
    output logic [4:0]       o_res_rd,
    output logic             o_illegal,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_retired_count
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [31:0]       r_instr;
    logic              r_instr_ready;
    logic [4:0]        r_dp_rs1;
    logic [4:0]        r_dp_rs2;
    logic [4:0]        r_dp_rd;
    logic [6:0]        r_dp_opcode;
    logic [3:0]        r_dp_opsel;
    logic [11:0]       r_dp_imm;
    logic              r_dp_reg_write;
    logic              r_res_valid;
    logic [XLEN-1:0]   r_res_data;
    logic              r_res_zero;
    logic [4:0]        r_res_rd;
    logic              r_illegal;
    logic              r_busy;
    logic [CNT_W-1:0]  r_count;

    // Fields of the latched instruction word
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [11:0] w_imm;
    logic [3:0]  w_opsel;
    logic        w_illegal;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];
    assign w_funct7 = r_instr[31:25];
    assign w_imm    = r_instr[31:20];

    // Decode the ALU select and check legality of the latched instruction.
    // The upper opsel bit comes from funct7[5] only where RV32I gives it a
    // meaning: SUB/SRA for R-type, and SRAI for OP-IMM. For other OP-IMM
    // operations, instr[30] is just an immediate bit, so it must not leak
    // into the select.
    always_comb begin
        w_illegal = 1'b0;
        w_opsel   = {1'b0, w_funct3};
        case (w_opcode)
            OP_R: begin
                w_opsel = {w_funct7[5], w_funct3};
                if (w_funct7 != 7'b0 && w_funct7 != F7_ALT)
                    w_illegal = 1'b1;
                else if (w_funct7 == F7_ALT && w_funct3 != 3'b000 && w_funct3 != 3'b101)
                    w_illegal = 1'b1;
            end
            OP_IMM: begin
                if (w_funct3 == 3'b101) begin
                    w_opsel = {r_instr[30], w_funct3};
                    if (w_funct7 != 7'b0 && w_funct7 != F7_ALT)
                        w_illegal = 1'b1;
                end else if (w_funct3 == 3'b001 && w_funct7 != 7'b0) begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_instr        <= '0;
            r_instr_ready  <= 1'b1;
            r_dp_rs1       <= '0;
            r_dp_rs2       <= '0;
            r_dp_rd        <= '0;
            r_dp_opcode    <= '0;
            r_dp_opsel     <= '0;
            r_dp_imm       <= '0;
            r_dp_reg_write <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_data     <= '0;
            r_res_zero     <= 1'b0;
            r_res_rd       <= '0;
            r_illegal      <= 1'b0;
            r_busy         <= 1'b0;
            r_count        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // ready is high throughout IDLE, so valid alone completes the handshake
                    if (i_instr_valid) begin
                        r_instr       <= i_instr;
                        r_instr_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_illegal) begin
                        // leave the datapath fields untouched; nothing gets written
                        r_illegal <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_dp_rs1    <= w_rs1;
                        r_dp_rs2    <= w_rs2;
                        r_dp_rd     <= w_rd;
                        r_dp_opcode <= w_opcode;
                        r_dp_opsel  <= w_opsel;
                        r_dp_imm    <= w_imm;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // x0 is architecturally zero, so never raise a write for it
                    r_dp_reg_write <= (r_dp_rd != 5'd0);
                    r_state        <= S_WB;
                end
                S_WB: begin
                    // the ALU output and the zero flag are both valid at the end of WB
                    r_dp_reg_write <= 1'b0;
                    r_res_data     <= i_dp_alu_out;
                    r_res_zero     <= i_dp_zero;
                    r_res_rd       <= r_dp_rd;
                    r_res_valid    <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_DONE: begin
                    // hold the result until the consumer takes it
                    if (i_res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_count       <= r_count + CNT_W'(1);
                        r_instr_ready <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_ERR: begin
                    r_illegal     <= 1'b0;
                    r_instr_ready <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_illegal      <= 1'b0;
                    r_dp_reg_write <= 1'b0;
                    r_res_valid    <= 1'b0;
                    r_instr_ready  <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign o_instr_ready   = r_instr_ready;
    assign o_dp_rs1        = r_dp_rs1;
    assign o_dp_rs2        = r_dp_rs2;
    assign o_dp_rd         = r_dp_rd;
    assign o_dp_opcode     = r_dp_opcode;
    assign o_dp_opsel      = r_dp_opsel;
    assign o_dp_imm        = r_dp_imm;
    assign o_dp_reg_write  = r_dp_reg_write;
    assign o_res_valid     = r_res_valid;
    assign o_res_data      = r_res_data;
    assign o_res_zero      = r_res_zero;
    assign o_res_rd        = r_res_rd;
    assign o_illegal       = r_illegal;
    assign o_busy          = r_busy;
    assign o_retired_count = r_count;

endmodule
